// File: rtl/ysyx_22040931_mem_arb.sv
// IF / LS arbiter sharing one memory port. One transaction in flight; owner gets the response.
// Build option YSYX_22040931_ARB_RR_EN: round-robin instead of LS priority with starvation guard.
module ysyx_22040931_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  input  logic                if_rsp_ready,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_rsp_valid,
  input  logic                ls_rsp_ready,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam logic OWN_LS = 1'b0;
  localparam logic OWN_IF = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  logic [1:0] state, state_nxt;
  logic       owner;
  mem_req_t   req_q, req_d;
  logic       idle_en, if_win, ls_win, grant;
  logic       in_rsp, owner_rdy;

  // Gating with reset keeps the ready pulses low while reset is held.
  assign idle_en = (state == S_IDLE) && reset;

`ifdef YSYX_22040931_ARB_RR_EN
  logic last_owner;

  always_comb begin
    if_win = if_req_valid;
    if (if_req_valid && ls_req_valid) if_win = (last_owner == OWN_LS);
  end

  // Starts as IF so the first contested grant after reset still goes to LS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     last_owner <= OWN_IF;
    else if (grant) last_owner <= if_win ? OWN_IF : OWN_LS;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  assign if_win = if_req_valid && (!ls_req_valid || starve_cnt == STARVE_LIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_cnt <= '0;
    else if (grant) begin
      if (if_req_valid && !if_win) starve_cnt <= starve_cnt + 4'd1;
      else                         starve_cnt <= '0;
    end
  end
`endif

  assign ls_win       = ls_req_valid && !if_win;
  assign grant        = idle_en && (if_win || ls_win);
  assign if_req_ready = idle_en && if_win;
  assign ls_req_ready = idle_en && ls_win;

  always_comb begin
    req_d = '0;
    if (if_win) begin
      req_d.addr = if_req_addr;
    end else begin
      req_d.addr  = ls_req_addr;
      req_d.wr    = ls_req_wr;
      req_d.wdata = ls_req_wdata;
      req_d.wmask = ls_req_wr ? ls_req_wmask : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant)                          state_nxt = S_REQ;
      S_REQ:   if (mem_req_ready)                  state_nxt = S_RSP;
      S_RSP:   if (mem_rsp_valid && mem_rsp_ready) state_nxt = S_IDLE;
      default:                                     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      owner <= OWN_LS;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= if_win ? OWN_IF : OWN_LS;
        req_q <= req_d;
      end
    end
  end

  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wr    = req_q.wr;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_wmask = req_q.wmask;

  // Response path is combinational; only the owner ever sees valid or data.
  assign in_rsp        = (state == S_RSP);
  assign owner_rdy     = (owner == OWN_IF) ? if_rsp_ready : ls_rsp_ready;
  assign mem_rsp_ready = in_rsp && owner_rdy;
  assign if_rsp_valid  = in_rsp && (owner == OWN_IF) && mem_rsp_valid;
  assign ls_rsp_valid  = in_rsp && (owner == OWN_LS) && mem_rsp_valid;
  assign if_rsp_data   = (in_rsp && owner == OWN_IF) ? mem_rsp_data : '0;
  assign ls_rsp_data   = (in_rsp && owner == OWN_LS) ? mem_rsp_data : '0;

endmodule

// File: tb/tb_ysyx_22040931_mem_arb.sv
// Directed bench for ysyx_22040931_mem_arb: reset, routing, arbitration order, backpressure, reset abort.
module tb_ysyx_22040931_mem_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              if_req_valid, if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid, if_rsp_ready;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid, ls_req_ready;
  logic [ADDR_W-1:0] ls_req_addr;
  logic              ls_req_wr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic [MASK_W-1:0] ls_req_wmask;
  logic              ls_rsp_valid, ls_rsp_ready;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_rsp_valid, mem_rsp_ready;
  logic [DATA_W-1:0] mem_rsp_data;

  int tests = 0;
  int fails = 0;

  ysyx_22040931_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(3)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wr(ls_req_wr), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wr(mem_req_wr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    reset = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0200;
    ls_req_valid = 1'b1; ls_req_addr = 32'h0000_0100; ls_req_wr = 1'b0;
    ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hA5A5_A5A5_A5A5_A5A5;
    if_rsp_ready = 1'b1; ls_rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      flags = {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
               mem_req_valid, mem_rsp_ready, mem_req_wr};
      tests++;
      if (flags !== 7'd0 || mem_req_addr !== '0 || mem_req_wmask !== '0 ||
          if_rsp_data !== '0 || ls_rsp_data !== '0) begin
        fails++;
        $display("FAIL reset_outputs: flags=%b addr=%h got nonzero, required all 0", flags, mem_req_addr);
      end
    end
    tick();
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({ls_req_ready, if_req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL reset_first_grant: ls/if ready=%b required 10", {ls_req_ready, if_req_ready});
    end
    tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clock);
    tests++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0100 || mem_rsp_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_req: valid=%b addr=%h rsp_ready=%b required 1 00000100 0",
               mem_req_valid, mem_req_addr, mem_rsp_ready);
    end
    tick();
    @(negedge clock);
    tests++;
    if (ls_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0 || ls_rsp_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      fails++;
      $display("FAIL reset_first_rsp: ls_v=%b if_v=%b data=%h", ls_rsp_valid, if_rsp_valid, ls_rsp_data);
    end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_if_read();
    if_req_valid = 1'b1; if_req_addr = 32'h8000_0000;
    @(negedge clock);
    tests++;
    if ({if_req_ready, ls_req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL if_grant: if/ls ready=%b required 10", {if_req_ready, ls_req_ready});
    end
    tick();
    if_req_valid = 1'b0;
    @(negedge clock);
    tests++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wr !== 1'b0 ||
        mem_req_wmask !== '0) begin
      fails++;
      $display("FAIL if_mem_req: valid=%b addr=%h wr=%b mask=%h required 1 80000000 0 00",
               mem_req_valid, mem_req_addr, mem_req_wr, mem_req_wmask);
    end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1122_3344_5566_7788;
    @(negedge clock);
    tests++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 64'h1122_3344_5566_7788 ||
        ls_rsp_valid !== 1'b0 || mem_rsp_ready !== 1'b1) begin
      fails++;
      $display("FAIL if_rsp: if_v=%b data=%h ls_v=%b mrdy=%b required 1 1122334455667788 0 1",
               if_rsp_valid, if_rsp_data, ls_rsp_valid, mem_rsp_ready);
    end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_arb_order();
    logic [7:0] got;
    logic [7:0] exp;
    int n = 0;
`ifdef YSYX_22040931_ARB_RR_EN
    exp = 8'b1010_1010;
`else
    exp = 8'b1000_1000;
`endif
    got = '0;
    if_req_valid = 1'b1; if_req_addr = 32'h8000_0010;
    ls_req_valid = 1'b1; ls_req_addr = 32'h8000_0020; ls_req_wr = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge clock);
      if (if_req_ready && ls_req_ready) begin
        tests++; fails++;
        $display("FAIL arb_both_ready: both ready asserted at grant %0d", n);
      end
      if (if_req_ready || ls_req_ready) begin
        got[n] = if_req_ready;
        n++;
      end
      if (n < 8) tick();
    end
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL arb_timeout: saw %0d grants, required 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got[i] !== exp[i]) begin
        fails++;
        $display("FAIL arb_order[%0d]: winner_is_if=%b required %b", i, got[i], exp[i]);
      end
    end
    tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    tick();
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_req_backpressure();
    ls_req_valid = 1'b1; ls_req_wr = 1'b1; ls_req_addr = 32'h8000_1000;
    ls_req_wdata = 64'h0000_0000_DEAD_BEEF; ls_req_wmask = 8'h0F;
    mem_req_ready = 1'b0;
    @(negedge clock);
    tests++;
    if (ls_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_grant: ls_req_ready=%b required 1", ls_req_ready);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      ls_req_addr = 32'h0BAD_0000 + i; ls_req_wdata = '1; ls_req_wmask = 8'hFF;
      if_req_valid = 1'b1;
      @(negedge clock);
      tests++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_1000 || mem_req_wr !== 1'b1 ||
          mem_req_wdata !== 64'h0000_0000_DEAD_BEEF || mem_req_wmask !== 8'h0F ||
          if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall[%0d]: v=%b addr=%h wr=%b wd=%h m=%h rdy=%b%b required 1 80001000 1 deadbeef 0f 00",
                 i, mem_req_valid, mem_req_addr, mem_req_wr, mem_req_wdata, mem_req_wmask,
                 if_req_ready, ls_req_ready);
      end
    end
    tick();
    mem_req_ready = 1'b1; if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_wr = 1'b0;
    @(negedge clock);
    tests++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_1000) begin
      fails++;
      $display("FAIL bp_handshake: valid=%b addr=%h required 1 80001000", mem_req_valid, mem_req_addr);
    end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0000_0000_CAFE; ls_rsp_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 64'h0000_0000_0000_CAFE || mem_rsp_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_write_ack: v=%b data=%h mrdy=%b required 1 cafe 1", ls_rsp_valid, ls_rsp_data, mem_rsp_ready);
    end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    ls_req_valid = 1'b1; ls_req_wr = 1'b0; ls_req_addr = 32'h8000_2000;
    @(negedge clock);
    tests++;
    if (ls_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rbp_grant: ls_req_ready=%b required 1", ls_req_ready);
    end
    tick();
    ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0000_0000_55AA; ls_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clock);
      tests++;
      if (mem_rsp_ready !== 1'b0 || ls_rsp_valid !== 1'b1 || ls_rsp_data !== 64'h55AA) begin
        fails++;
        $display("FAIL rbp_stall[%0d]: mrdy=%b ls_v=%b data=%h required 0 1 55aa",
                 i, mem_rsp_ready, ls_rsp_valid, ls_rsp_data);
      end
    end
    tick();
    ls_rsp_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (mem_rsp_ready !== 1'b1 || ls_rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rbp_release: mrdy=%b ls_v=%b required 1 1", mem_rsp_ready, ls_rsp_valid);
    end
    tick();
    @(negedge clock);
    tests++;
    if (mem_rsp_ready !== 1'b0 || ls_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL rbp_idle: mrdy=%b ls_v=%b mreq_v=%b required 0 0 0", mem_rsp_ready, ls_rsp_valid, mem_req_valid);
    end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_mid_rsp();
    ls_req_valid = 1'b1; ls_req_wr = 1'b0; ls_req_addr = 32'h8000_3000;
    @(negedge clock);
    tick();
    ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b0; ls_rsp_ready = 1'b0; mem_rsp_data = 64'h1234;
    @(negedge clock);
    tests++;
    if (mem_req_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_in_rsp: mreq_v=%b ls_v=%b required 0 0", mem_req_valid, ls_rsp_valid);
    end
    #1 reset = 1'b0; mem_rsp_valid = 1'b1; ls_rsp_ready = 1'b1;
    #1;
    tests++;
    if (mem_req_valid !== 1'b0 || mem_rsp_ready !== 1'b0 || ls_rsp_valid !== 1'b0 ||
        mem_req_addr !== '0 || ls_rsp_data !== '0) begin
      fails++;
      $display("FAIL abort_reset: mreq_v=%b mrdy=%b ls_v=%b addr=%h required all 0",
               mem_req_valid, mem_rsp_ready, ls_rsp_valid, mem_req_addr);
    end
    tick();
    tick();
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (mem_rsp_ready !== 1'b0 || ls_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_stray: mrdy=%b ls_v=%b if_v=%b mreq_v=%b required 0 0 0 0",
               mem_rsp_ready, ls_rsp_valid, if_rsp_valid, mem_req_valid);
    end
    tick();
    mem_rsp_valid = 1'b0; ls_req_valid = 1'b1; ls_req_addr = 32'h8000_4000;
    @(negedge clock);
    tests++;
    if (ls_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_next_grant: ls_req_ready=%b required 1", ls_req_ready);
    end
    tick();
    ls_req_valid = 1'b0;
    @(negedge clock);
    tests++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_4000) begin
      fails++;
      $display("FAIL abort_next_req: v=%b addr=%h required 1 80004000", mem_req_valid, mem_req_addr);
    end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0BEE_F00D;
    @(negedge clock);
    tests++;
    if (ls_rsp_valid !== 1'b1 || ls_rsp_data !== 64'h0BEE_F00D) begin
      fails++;
      $display("FAIL abort_next_rsp: v=%b data=%h required 1 0beef00d", ls_rsp_valid, ls_rsp_data);
    end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_arb_order();
    test_req_backpressure();
    test_rsp_backpressure();
    test_reset_mid_rsp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_22040931_mem_arb.md
Name: ysyx_22040931_mem_arb

Overview:
Two-requester arbiter that shares the single memory port between instruction fetch (IF) and the load/store path (LS, fed by EX mem_addr/mem_data/mem_wr).
- One transaction outstanding at a time; requests are registered at grant and responses are routed back to the owner.
- Sits between the IF/MEM stages and the memory bus; all interfaces use valid/ready handshakes.

Parameters:
ADDR_W, 32, memory address width (matches MEM bus)
DATA_W, 64, data width
STARVE_MAX, 3, consecutive IF losses before IF is forced to win (1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req_valid  in  1  IF read request
if_req_ready  out  1  IF request accepted this cycle
if_req_addr  in  ADDR_W  IF address
if_rsp_valid  out  1  IF response valid
if_rsp_ready  in  1  IF accepts response
if_rsp_data  out  DATA_W  IF read data
ls_req_valid  in  1  LS request
ls_req_ready  out  1  LS request accepted this cycle
ls_req_addr  in  ADDR_W  LS address
ls_req_wr  in  1  1 = write, 0 = read
ls_req_wdata  in  DATA_W  write data
ls_req_wmask  in  DATA_W/8  byte write mask
ls_rsp_valid  out  1  LS response valid (read data or write ack)
ls_rsp_ready  in  1  LS accepts response
ls_rsp_data  out  DATA_W  LS read data
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  ADDR_W  registered address
mem_req_wr  out  1  registered write flag
mem_req_wdata  out  DATA_W  registered write data
mem_req_wmask  out  DATA_W/8  registered mask; 0 for reads
mem_rsp_valid  in  1  bus response
mem_rsp_ready  out  1  arbiter accepts response
mem_rsp_data  in  DATA_W  bus read data

Behaviour:
- States:
  - IDLE: arbitrate; on grant, pulse the winner's req_ready for 1 cycle, latch its fields and owner into registers, then go to REQ.
  - REQ: mem_req_valid=1 with stable registered fields. Go to RSP on mem_req_valid & mem_req_ready.
  - RSP: owner_rsp_valid = mem_rsp_valid; owner_rsp_data = mem_rsp_data (combinational); mem_rsp_ready = owner_rsp_ready. Go to IDLE on the mem_rsp handshake.
- Arbitration:
  - LS has fixed priority.
  - starve_cnt (4 bit) increments when IF is valid and LS wins, and clears when IF wins or IF is not valid at a grant.
  - When starve_cnt == STARVE_MAX and both are valid, IF wins.
- req_ready is asserted only in IDLE for the winner, never both in the same cycle. A request that is not accepted must be held by the requester (no drop).
- Latency:
  - Grant at cycle T; mem_req_valid from T+1.
  - With zero-wait memory, the response handshake is at T+2 and the next grant at T+3.
- The non-owner's rsp_valid is always 0. A mem_rsp_valid seen in IDLE or REQ is ignored (mem_rsp_ready=0).
- Backpressure: REQ and RSP hold indefinitely; registered fields do not change until completion.
- Writes still wait for a response (ack); ls_rsp_data passes mem_rsp_data unchanged.
- Reset (async assert, sync deassert assumed upstream): return to IDLE from any state, including mid-REQ/RSP.
  - All outputs 0; registered fields 0; starve_cnt 0; owner = LS.
  - The aborted transaction is not replayed.

Optional Feature:
YSYX_22040931_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit last_owner register gives the non-last requester priority when both are valid; starve_cnt is removed.
- Undefined: LS fixed priority with the STARVE_MAX starvation guard described above.

Test Plan:
1. Hold reset=0 for 3 cycles with both requests valid -> all ready/valid outputs 0. Release -> first grant goes to LS (fixed-priority build).
2. IF-only read, addr 0x80000000; mem_req_ready=1 and mem_rsp_data=0x1122334455667788 at T+2 -> if_req_ready pulses at T, mem_req_addr=0x80000000 with wr=0 and mask=0, if_rsp_valid with that data, ls_rsp_valid stays 0.
3. IF and LS both valid continuously, STARVE_MAX=3, zero-wait memory -> grant order LS,LS,LS,IF,LS,LS,LS,IF. With RR_EN: LS,IF,LS,IF.
4. LS write addr 0x80001000, wdata 0xDEADBEEF, mask 0x0F; mem_req_ready held 0 for 5 cycles -> mem_req fields stable for all 5 cycles, no req_ready pulses, handshake on the 6th cycle.
5. LS read; mem_rsp_valid=1 while ls_rsp_ready=0 for 3 cycles -> mem_rsp_ready=0 for those cycles, ls_rsp_valid=1 throughout; completes and returns to IDLE in the cycle ls_rsp_ready=1.
6. Assert reset while in RSP, then drive a stray mem_rsp_valid after release -> outputs 0 immediately on reset; stray response ignored; next request served normally.
